// File: rtl/extnd.sv
// extnd: widens a 16-bit immediate to a 32-bit operand.
// Sign-extend, zero-extend, load-upper and signed-byte modes, one cycle of
// latency, with out_valid marking a cycle whose data came from a valid input.
module extnd #(
  parameter int unsigned    IN_W        = 16,
  parameter int unsigned    OUT_W       = 32,
  parameter logic [OUT_W-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  data_16bit,
  input  logic [1:0]       ext_op,
  input  logic             in_valid,
  output logic [OUT_W-1:0] data_32bit,
  output logic             out_valid
);

  localparam int unsigned PAD_W  = OUT_W - IN_W;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BPAD_W = OUT_W - BYTE_W;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BYTE  = 2'b11
  } ext_op_e;

  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_data;
  logic             r_valid;

  // Select the extended value for the current mode; sign-extend is the default.
  always_comb begin
    w_ext = {{PAD_W{data_16bit[IN_W-1]}}, data_16bit};
    case (ext_op_e'(ext_op))
      EXT_SIGN:  w_ext = {{PAD_W{data_16bit[IN_W-1]}}, data_16bit};
      EXT_ZERO:  w_ext = {{PAD_W{1'b0}}, data_16bit};
      EXT_UPPER: w_ext = {data_16bit, {PAD_W{1'b0}}};
      EXT_BYTE:  w_ext = {{BPAD_W{data_16bit[BYTE_W-1]}}, data_16bit[BYTE_W-1:0]};
      default:   w_ext = {{PAD_W{data_16bit[IN_W-1]}}, data_16bit};
    endcase
  end

  // Output registers: reset wins, data holds when no valid input arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= RESET_VALUE;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_ext;
      end
    end
  end

  assign data_32bit = r_data;
  assign out_valid  = r_valid;

endmodule

// File: tb/tb_extnd.sv
// Self-checking bench for extnd: directed vector table, hand-written
// hold/reset-priority sequences, and random traffic against a reference model.
module tb_extnd;

  logic        clk;
  logic        rst;
  logic [15:0] data_16bit;
  logic [1:0]  ext_op;
  logic        in_valid;
  logic [31:0] data_32bit;
  logic        out_valid;

  int n_pass;
  int n_total;

  // Reference model state
  logic [31:0] m_data;
  logic        m_valid;

  typedef struct {
    logic        r;
    logic        v;
    logic [1:0]  op;
    logic [15:0] d;
    logic [31:0] ed;
    logic        ev;
    string       name;
  } vec_t;

  vec_t vecs[$];

  extnd dut (
    .clk        (clk),
    .rst        (rst),
    .data_16bit (data_16bit),
    .ext_op     (ext_op),
    .in_valid   (in_valid),
    .data_32bit (data_32bit),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Extension rules expressed as signed/unsigned arithmetic.
  function automatic logic [31:0] ref_ext(input logic [1:0] op, input logic [15:0] d);
    logic signed [15:0] sh;
    logic signed [7:0]  sb;
    int signed          s;
    sh = d;
    sb = d[7:0];
    case (op)
      2'd0:    begin s = sh; return 32'(s); end
      2'd1:    return 32'(d);
      2'd2:    return 32'(d) * 32'd65536;
      default: begin s = sb; return 32'(s); end
    endcase
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                              input logic [15:0] d, input logic [31:0] ed,
                              input logic ev, input string name);
    vec_t t;
    t.r = r; t.v = v; t.op = op; t.d = d; t.ed = ed; t.ev = ev; t.name = name;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act_d, input logic act_v,
                       input logic [31:0] exp_d, input logic exp_v);
    n_total++;
    if (act_d === exp_d && act_v === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got data=%h valid=%b, required data=%h valid=%b",
               name, act_d, act_v, exp_d, exp_v);
    end
  endtask

  // Drive one cycle, let the edge happen, then compare.
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [15:0] d, input logic [31:0] ed, input logic ev,
                      input string name);
    rst        = r;
    in_valid   = v;
    ext_op     = op;
    data_16bit = d;
    @(posedge clk);
    #1;
    check(name, data_32bit, out_valid, ed, ev);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    ext_op     = 2'b00;
    data_16bit = 16'h0000;

    // Directed vectors: one row per clock edge
    vecs.push_back(mk(1, 1, 2'b00, 16'hFFFF, 32'h0000_0000, 0, "reset_0"));
    vecs.push_back(mk(1, 1, 2'b00, 16'hFFFF, 32'h0000_0000, 0, "reset_1"));
    vecs.push_back(mk(0, 1, 2'b00, 16'hFFFF, 32'hFFFF_FFFF, 1, "sext_ffff"));
    vecs.push_back(mk(0, 1, 2'b00, 16'h00AA, 32'h0000_00AA, 1, "sext_00aa"));
    vecs.push_back(mk(0, 1, 2'b01, 16'h8001, 32'h0000_8001, 1, "zext_8001"));
    vecs.push_back(mk(0, 1, 2'b10, 16'h1234, 32'h1234_0000, 1, "lui_1234"));
    vecs.push_back(mk(0, 1, 2'b11, 16'h1280, 32'hFFFF_FF80, 1, "byte_1280"));
    vecs.push_back(mk(0, 1, 2'b11, 16'hFF7F, 32'h0000_007F, 1, "byte_ff7f"));
    vecs.push_back(mk(0, 1, 2'b00, 16'h7FFF, 32'h0000_7FFF, 1, "sext_7fff"));
    vecs.push_back(mk(0, 0, 2'b01, 16'h1111, 32'h0000_7FFF, 0, "idle_hold"));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].ed, vecs[i].ev, vecs[i].name);
    end

    // Hold: a valid 8000 then three idle cycles with toggling data
    step(0, 1, 2'b00, 16'h8000, 32'hFFFF_8000, 1, "sext_8000");
    step(0, 0, 2'b00, 16'hAAAA, 32'hFFFF_8000, 0, "hold_0");
    step(0, 0, 2'b10, 16'h5555, 32'hFFFF_8000, 0, "hold_1");
    step(0, 0, 2'b11, 16'hAAAA, 32'hFFFF_8000, 0, "hold_2");

    // Reset beats a valid input on the same edge; next valid goes through
    step(1, 1, 2'b00, 16'h7FFF, 32'h0000_0000, 0, "rst_prio");
    step(0, 1, 2'b00, 16'h7FFF, 32'h0000_7FFF, 1, "after_rst");

    // Random traffic against the reference model
    m_data  = 32'h0000_7FFF;
    m_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic        r;
      logic        v;
      logic [1:0]  op;
      logic [15:0] d;
      r  = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      if (r) begin
        m_data  = 32'h0000_0000;
        m_valid = 1'b0;
      end else begin
        m_valid = v;
        if (v) m_data = ref_ext(op, d);
      end
      step(r, v, op, d, m_data, m_valid, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/extnd.md
Name: extnd

Overview:
- Immediate-extension unit for the datapath: widens a 16-bit immediate to a 32-bit operand for the ALU, address and load-upper paths.
- Supports sign-extend, zero-extend, load-upper and signed-byte modes.
- Output is registered, with one clock of latency and a valid flag.
- Sits between instruction decode (immediate field) and the ALU operand mux.

Parameters:
- IN_W, 16, input immediate width; this revision supports only 16.
- OUT_W, 32, output width; this revision supports only 32.
- RESET_VALUE, 32'h0000_0000, value loaded into data_32bit on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- data_16bit  input  16  immediate to extend.
- ext_op  input  2  extension mode select (encodings below).
- in_valid  input  1  qualifies data_16bit/ext_op this cycle.
- data_32bit  output  32  registered extended result.
- out_valid  output  1  high for one cycle when data_32bit was updated from a valid input.

Behaviour:
- Reset (rst=1 at a rising edge):
  - data_32bit <= RESET_VALUE; out_valid <= 0.
  - rst takes priority over in_valid on the same edge.
  - A transaction presented on that edge is discarded.
- ext_op encodings, with d = data_16bit:
  - 2'b00 sign-extend: {{16{d[15]}}, d}. This is the default mode.
  - 2'b01 zero-extend: {16'h0000, d}.
  - 2'b10 load-upper: {d, 16'h0000}.
  - 2'b11 signed byte: {{24{d[7]}}, d[7:0]}; d[15:8] is ignored.
- Latency: inputs sampled at edge N appear on data_32bit after edge N, and out_valid=1 during cycle N+1.
- Valid handling:
  - in_valid=1 at an edge: data_32bit loads the extended value; out_valid <= 1.
  - in_valid=0 at an edge: data_32bit holds its previous value; out_valid <= 0.
- Throughput: one result per clock. Back-to-back valid inputs produce back-to-back results with no bubbles.
- No backpressure and no internal state beyond the output registers; no FSM.
- Purely bitwise. No arithmetic, overflow or saturation.
- Boundary values:
  - 16'h8000 sign-extends to 32'hFFFF_8000.
  - 16'h7FFF sign-extends to 32'h0000_7FFF.
  - Byte mode with d[7]=1 fills bits 31:8 with ones.
- X on ext_op while in_valid=1 is a protocol violation; output is undefined and not checked.
- Reset mid-stream: the next valid input after rst deasserts is processed normally, with the same one-cycle latency.

Test Plan:
- Reset:
  - Hold rst=1 for 2 cycles with in_valid=1 and data_16bit=16'hFFFF.
  - Required: data_32bit=32'h0000_0000 and out_valid=0 throughout.
- Sign-extend:
  - ext_op=00, in_valid=1, data_16bit=16'hFFFF then 16'h00AA on consecutive cycles.
  - Required: data_32bit=32'hFFFF_FFFF then 32'h0000_00AA, one cycle after each; out_valid=1 on both cycles.
- Zero-extend and load-upper:
  - ext_op=01, data_16bit=16'h8001. Required: 32'h0000_8001.
  - Then ext_op=10, data_16bit=16'h1234. Required: 32'h1234_0000.
- Signed byte:
  - ext_op=11, data_16bit=16'h1280. Required: 32'hFFFF_FF80.
  - Then data_16bit=16'hFF7F. Required: 32'h0000_007F.
- Hold behaviour:
  - After a valid 16'h8000 (ext_op=00) yields 32'hFFFF_8000, drop in_valid for 3 cycles while data_16bit toggles.
  - Required: data_32bit stays 32'hFFFF_8000 and out_valid=0 during those 3 cycles.
- Reset priority:
  - Assert rst on the same edge as a valid 16'h7FFF.
  - Required: output is 32'h0 with out_valid=0.
  - A valid 16'h7FFF on the next edge then yields 32'h0000_7FFF.
